write_addr_arbiter: RTL and testbench
=====================================

WRITE_ADDR_ARBITER -- requirements
Module: write_addr_arbiter

Interface
REQ-001 SHALL have ports: ACLK  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: ARESET  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: AWVALID_M0, AWVALID_M1  in  1 each  master write-address requests.
REQ-004 SHALL have ports: AWADDR_M0, AWADDR_M1  in  `AXI_ADDR_BITS each  request addresses.
REQ-005 SHALL have ports: AWREADY_M0, AWREADY_M1  in  1 each  AW handshake completion, from the write address channel mux.
REQ-006 SHALL have ports: BVALID_M0, BREADY_M0, BVALID_M1, BREADY_M1  in  1 each  write-response handshake per master.
REQ-007 SHALL have ports: AW_arbiter  out  `MX_SX_ID_BITS  route code; one of `Mm_Ss_W (m=0..1, s=0..5) or `NO_GRANT_W.
REQ-008 SHALL have ports: DECERR_M0, DECERR_M1  out  1 each  unmapped write owned by the default slave.
REQ-009 `NO_GRANT_W SHALL be added to BUS_direct_def.svh with a value distinct from every `Mm_Ss_W code.

Function
REQ-010 Address decode SHALL be: S0 0x0000_0000-0x0000_3FFF; S1 0x0001_0000-0x0001_FFFF; S2 0x0002_0000-0x0002_FFFF; S3 0x1000_0000-0x1000_03FF; S4 0x1001_0000-0x1001_03FF; S5 0x2000_0000-0x201F_FFFF; all else unmapped.
REQ-011 FSM states SHALL be IDLE, ADDR, RESP, DECERR; AW_arbiter and DECERR_Mx SHALL be registered outputs.
REQ-012 IDLE: AW_arbiter=`NO_GRANT_W, DECERR_Mx=0; on any AWVALID, select a winner per REQ-016 and latch master and decoded slave.
REQ-013 IDLE transition: go to ADDR with a mapped address, or to DECERR with an unmapped address; the grant SHALL be visible one cycle after the request is sampled.
REQ-014 ADDR: hold AW_arbiter=`Mw_Ss_W and ignore AWVALID deassertion; on AWREADY_Mw=1 go to RESP.
REQ-015 RESP: hold the same code so the W/B routing stays stable; on BVALID_Mw&BREADY_Mw go to IDLE.
REQ-015a DECERR: hold DECERR_Mw=1 and AW_arbiter=`NO_GRANT_W; on BVALID_Mw&BREADY_Mw go to IDLE.
REQ-016 Winner selection: only one requester wins; with both requesting, the master named by the priority pointer wins. The pointer is 1 bit, reset to M0, and updates when leaving IDLE.
REQ-017 Only one outstanding write at a time; the non-granted master's AWVALID SHALL be ignored until IDLE.
REQ-018 Release and a new grant SHALL NOT happen in the same cycle; the minimum gap between grants is one IDLE cycle.
REQ-019 A B handshake belonging to the non-granted master SHALL be ignored.

Reset
REQ-020 ARESET=1 SHALL force IDLE, AW_arbiter=`NO_GRANT_W, DECERR_M0=DECERR_M1=0 and pointer=M0 immediately, regardless of ACLK.
REQ-021 A reset in ADDR, RESP or DECERR SHALL abandon the transaction; after ARESET falls, the first grant needs a fresh AWVALID sample.

Configuration
REQ-022 Macro AW_RR_EN defined: the pointer SHALL move to the loser after each grant (round-robin).
REQ-023 Macro AW_RR_EN undefined: the pointer logic SHALL be absent and M0 SHALL always beat M1 (fixed priority).

Verification
REQ-024 Single request: AWVALID_M0=1, AWADDR_M0=0x0001_0040. Next cycle AW_arbiter=`M0_S1_W. AWREADY_M0 pulse leads to RESP. BVALID_M0&BREADY_M0 leads to `NO_GRANT_W one cycle later.
REQ-025 Simultaneous requests (AW_RR_EN), M0 to 0x0002_0000 and M1 to 0x2000_0010, held: grants in order `M0_S2_W then `M1_S5_W. With AW_RR_EN undefined, M0 repeats while it keeps requesting.
REQ-026 Unmapped address: AWVALID_M1=1, AWADDR_M1=0x3000_0000. Next cycle DECERR_M1=1 and AW_arbiter=`NO_GRANT_W; both clear after BVALID_M1&BREADY_M1.
REQ-027 Grant stability: in RESP for `M0_S3_W, raise AWVALID_M1 and pulse BVALID_M1&BREADY_M1. AW_arbiter stays `M0_S3_W and M1 is not granted before IDLE.
REQ-028 Reset mid-operation: assert ARESET between clock edges while in RESP. Outputs go to `NO_GRANT_W and DECERR=0 before the next edge. After release, the next grant goes to M0 when both masters request.

Source files
------------

// File: rtl/write_addr_arbiter.sv
// Write-address arbiter for two AXI masters onto six slaves; one outstanding write at a time.
// Define AW_RR_EN for round-robin priority; undefined gives fixed priority with M0 first.

`ifndef BUS_DIRECT_DEF_SVH
`define BUS_DIRECT_DEF_SVH
`define AXI_ADDR_BITS 32
`define MX_SX_ID_BITS 4
`define M0_S0_W 4'd0
`define M0_S1_W 4'd1
`define M0_S2_W 4'd2
`define M0_S3_W 4'd3
`define M0_S4_W 4'd4
`define M0_S5_W 4'd5
`define M1_S0_W 4'd6
`define M1_S1_W 4'd7
`define M1_S2_W 4'd8
`define M1_S3_W 4'd9
`define M1_S4_W 4'd10
`define M1_S5_W 4'd11
`define NO_GRANT_W 4'd15
`endif

module write_addr_arbiter (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      AWVALID_M0,
  input  logic                      AWVALID_M1,
  input  logic [`AXI_ADDR_BITS-1:0] AWADDR_M0,
  input  logic [`AXI_ADDR_BITS-1:0] AWADDR_M1,
  input  logic                      AWREADY_M0,
  input  logic                      AWREADY_M1,
  input  logic                      BVALID_M0,
  input  logic                      BREADY_M0,
  input  logic                      BVALID_M1,
  input  logic                      BREADY_M1,
  output logic [`MX_SX_ID_BITS-1:0] AW_arbiter,
  output logic                      DECERR_M0,
  output logic                      DECERR_M1
);

  typedef enum logic [1:0] {IDLE, ADDR, RESP, DECERR} state_t;

  state_t                      state_reg, state_next;
  logic                        master_reg, master_next;
  logic [2:0]                  slave_reg, slave_next;
  logic [`MX_SX_ID_BITS-1:0]   aw_arbiter_next;
  logic                        decerr_m0_next, decerr_m1_next;
  logic                        winner;
  logic [`AXI_ADDR_BITS-1:0]   sel_addr;
  logic [3:0]                  dec;
  logic                        awready_own, bdone_own;

  // Returns {mapped, slave index}.
  function automatic logic [3:0] decode(input logic [`AXI_ADDR_BITS-1:0] a);
    if (a <= 32'h0000_3FFF)                             return 4'b1_000;
    else if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF)  return 4'b1_001;
    else if (a >= 32'h0002_0000 && a <= 32'h0002_FFFF)  return 4'b1_010;
    else if (a >= 32'h1000_0000 && a <= 32'h1000_03FF)  return 4'b1_011;
    else if (a >= 32'h1001_0000 && a <= 32'h1001_03FF)  return 4'b1_100;
    else if (a >= 32'h2000_0000 && a <= 32'h201F_FFFF)  return 4'b1_101;
    else                                                return 4'b0_000;
  endfunction

  function automatic logic [`MX_SX_ID_BITS-1:0] route(input logic m, input logic [2:0] s);
    case ({m, s})
      4'b0_000: return `M0_S0_W;
      4'b0_001: return `M0_S1_W;
      4'b0_010: return `M0_S2_W;
      4'b0_011: return `M0_S3_W;
      4'b0_100: return `M0_S4_W;
      4'b0_101: return `M0_S5_W;
      4'b1_000: return `M1_S0_W;
      4'b1_001: return `M1_S1_W;
      4'b1_010: return `M1_S2_W;
      4'b1_011: return `M1_S3_W;
      4'b1_100: return `M1_S4_W;
      4'b1_101: return `M1_S5_W;
      default:  return `NO_GRANT_W;
    endcase
  endfunction

`ifdef AW_RR_EN
  logic pointer_reg;

  always_comb winner = (AWVALID_M0 && AWVALID_M1) ? pointer_reg : !AWVALID_M0;

  // The loser of each grant gets priority next time.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)
      pointer_reg <= 1'b0;
    else if (state_reg == IDLE && (AWVALID_M0 || AWVALID_M1))
      pointer_reg <= !winner;
  end
`else
  always_comb winner = !AWVALID_M0;
`endif

  always_comb begin
    sel_addr    = winner ? AWADDR_M1 : AWADDR_M0;
    dec         = decode(sel_addr);
    awready_own = master_reg ? AWREADY_M1 : AWREADY_M0;
    bdone_own   = master_reg ? (BVALID_M1 && BREADY_M1) : (BVALID_M0 && BREADY_M0);
  end

  always_comb begin
    state_next  = state_reg;
    master_next = master_reg;
    slave_next  = slave_reg;
    case (state_reg)
      IDLE: begin
        if (AWVALID_M0 || AWVALID_M1) begin
          master_next = winner;
          slave_next  = dec[2:0];
          state_next  = dec[3] ? ADDR : DECERR;
        end
      end
      ADDR:    if (awready_own) state_next = RESP;
      RESP:    if (bdone_own)   state_next = IDLE;
      DECERR:  if (bdone_own)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    aw_arbiter_next = `NO_GRANT_W;
    decerr_m0_next  = 1'b0;
    decerr_m1_next  = 1'b0;
    if (state_next == ADDR || state_next == RESP)
      aw_arbiter_next = route(master_next, slave_next);
    if (state_next == DECERR) begin
      decerr_m0_next = !master_next;
      decerr_m1_next = master_next;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg  <= IDLE;
      master_reg <= 1'b0;
      slave_reg  <= 3'd0;
      AW_arbiter <= `NO_GRANT_W;
      DECERR_M0  <= 1'b0;
      DECERR_M1  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      master_reg <= master_next;
      slave_reg  <= slave_next;
      AW_arbiter <= aw_arbiter_next;
      DECERR_M0  <= decerr_m0_next;
      DECERR_M1  <= decerr_m1_next;
    end
  end

endmodule

// File: tb/tb_write_addr_arbiter.sv
// Directed and randomized checks of write_addr_arbiter against a transaction-level model.
// The model follows the AW_RR_EN build option of the design.

module tb_write_addr_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        AWVALID_M0, AWVALID_M1;
  logic [31:0] AWADDR_M0, AWADDR_M1;
  logic        AWREADY_M0, AWREADY_M1;
  logic        BVALID_M0, BREADY_M0, BVALID_M1, BREADY_M1;
  logic [3:0]  AW_arbiter;
  logic        DECERR_M0, DECERR_M1;

  int errors = 0;
  int checks = 0;

  // Model: owner=-1 when no write outstanding.
  int owner;
  int slv;
  bit unmapped;
  bit addr_done;
  int prio;

  logic [31:0] addr_tab [12] = '{32'h0000_3FFF, 32'h0000_4000, 32'h0001_0000, 32'h0001_FFFF,
                                 32'h0002_FFFF, 32'h1000_03FF, 32'h1000_0400, 32'h1001_0000,
                                 32'h201F_FFFF, 32'h2020_0000, 32'h0000_0000, 32'hFFFF_FFFF};

  write_addr_arbiter dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID_M0(AWVALID_M0), .AWVALID_M1(AWVALID_M1),
    .AWADDR_M0(AWADDR_M0), .AWADDR_M1(AWADDR_M1),
    .AWREADY_M0(AWREADY_M0), .AWREADY_M1(AWREADY_M1),
    .BVALID_M0(BVALID_M0), .BREADY_M0(BREADY_M0),
    .BVALID_M1(BVALID_M1), .BREADY_M1(BREADY_M1),
    .AW_arbiter(AW_arbiter), .DECERR_M0(DECERR_M0), .DECERR_M1(DECERR_M1)
  );

  always #5 ACLK = ~ACLK;

  function automatic int slave_of(input logic [31:0] a);
    if (a < 32'h0000_4000) return 0;
    if (a >= 32'h0001_0000 && a < 32'h0002_0000) return 1;
    if (a >= 32'h0002_0000 && a < 32'h0003_0000) return 2;
    if (a >= 32'h1000_0000 && a < 32'h1000_0400) return 3;
    if (a >= 32'h1001_0000 && a < 32'h1001_0400) return 4;
    if (a >= 32'h2000_0000 && a < 32'h2020_0000) return 5;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; unmapped = 0; addr_done = 0; prio = 0; slv = 0;
  endtask

  task automatic model_edge();
    bit v0, v1, aw, bd;
    int w;
    if (ARESET) begin
      model_reset();
      return;
    end
    v0 = AWVALID_M0; v1 = AWVALID_M1;
    if (owner < 0) begin
      if (v0 || v1) begin
`ifdef AW_RR_EN
        w = (v0 && v1) ? prio : (v0 ? 0 : 1);
        prio = 1 - w;
`else
        w = v0 ? 0 : 1;
`endif
        owner = w;
        slv = slave_of(w == 0 ? AWADDR_M0 : AWADDR_M1);
        unmapped = (slv < 0);
        addr_done = 0;
      end
    end else begin
      aw = (owner == 0) ? AWREADY_M0 : AWREADY_M1;
      bd = (owner == 0) ? (BVALID_M0 && BREADY_M0) : (BVALID_M1 && BREADY_M1);
      if (!unmapped && !addr_done) begin
        if (aw) addr_done = 1;
      end else if (bd) begin
        owner = -1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    int exp_aw;
    exp_aw = (owner < 0 || unmapped) ? 15 : owner * 6 + slv;
    chk({tag, "_aw"}, 32'(AW_arbiter), 32'(exp_aw));
    chk({tag, "_de0"}, 32'(DECERR_M0), 32'(owner == 0 && unmapped));
    chk({tag, "_de1"}, 32'(DECERR_M1), 32'(owner == 1 && unmapped));
  endtask

  task automatic cyc(input string tag);
    @(posedge ACLK);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic clear_inputs();
    AWVALID_M0 = 0; AWVALID_M1 = 0; AWADDR_M0 = 0; AWADDR_M1 = 0;
    AWREADY_M0 = 0; AWREADY_M1 = 0;
    BVALID_M0 = 0; BREADY_M0 = 0; BVALID_M1 = 0; BREADY_M1 = 0;
  endtask

  // Completes whatever write is outstanding: AW pulse then B pulse on both masters.
  task automatic complete(input string tag);
    AWREADY_M0 = 1; AWREADY_M1 = 1; cyc(tag);
    AWREADY_M0 = 0; AWREADY_M1 = 0;
    BVALID_M0 = 1; BREADY_M0 = 1; BVALID_M1 = 1; BREADY_M1 = 1; cyc(tag);
    BVALID_M0 = 0; BREADY_M0 = 0; BVALID_M1 = 0; BREADY_M1 = 0;
  endtask

  initial begin
    ARESET = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge ACLK);
    #1;
    check_outputs("reset");
    ARESET = 1'b0;

    // Simultaneous requests held
    AWVALID_M0 = 1; AWADDR_M0 = 32'h0002_0000;
    AWVALID_M1 = 1; AWADDR_M1 = 32'h2000_0010;
    cyc("both1");
    chk("both_first", 32'(AW_arbiter), 32'd2);
    complete("both1c");
    cyc("both2");
`ifdef AW_RR_EN
    chk("both_second", 32'(AW_arbiter), 32'd11);
`else
    chk("both_second", 32'(AW_arbiter), 32'd2);
`endif
    AWVALID_M0 = 0; AWVALID_M1 = 0;
    complete("both2c");
    cyc("idle");

    // Single request
    AWVALID_M0 = 1; AWADDR_M0 = 32'h0001_0040;
    cyc("single");
    chk("single_grant", 32'(AW_arbiter), 32'd1);
    AWVALID_M0 = 0;
    cyc("single_hold");
    AWREADY_M0 = 1; cyc("single_aw"); AWREADY_M0 = 0;
    cyc("single_resp");
    BVALID_M0 = 1; BREADY_M0 = 1; cyc("single_b");
    chk("single_release", 32'(AW_arbiter), 32'd15);
    BVALID_M0 = 0; BREADY_M0 = 0;

    // Unmapped address
    AWVALID_M1 = 1; AWADDR_M1 = 32'h3000_0000;
    cyc("decerr");
    chk("decerr_flag", 32'(DECERR_M1), 32'd1);
    AWVALID_M1 = 0;
    cyc("decerr_hold");
    BVALID_M1 = 1; BREADY_M1 = 1; cyc("decerr_b");
    chk("decerr_clear", 32'(DECERR_M1), 32'd0);
    BVALID_M1 = 0; BREADY_M1 = 0;

    // Grant stability against the other master
    AWVALID_M0 = 1; AWADDR_M0 = 32'h1000_0100;
    cyc("stab");
    AWVALID_M0 = 0;
    AWREADY_M0 = 1; cyc("stab_aw"); AWREADY_M0 = 0;
    AWVALID_M1 = 1; AWADDR_M1 = 32'h0000_0010;
    BVALID_M1 = 1; BREADY_M1 = 1;
    cyc("stab_r1");
    cyc("stab_r2");
    chk("stab_hold", 32'(AW_arbiter), 32'd3);
    BVALID_M1 = 0; BREADY_M1 = 0;
    BVALID_M0 = 1; BREADY_M0 = 1; cyc("stab_b");
    chk("stab_gap", 32'(AW_arbiter), 32'd15);
    BVALID_M0 = 0; BREADY_M0 = 0;
    cyc("stab_m1");
    chk("stab_m1_grant", 32'(AW_arbiter), 32'd6);
    AWVALID_M1 = 0;
    complete("stab_c");

    // Reset in RESP between edges
    AWVALID_M0 = 1; AWADDR_M0 = 32'h0001_0000;
    AWVALID_M1 = 1; AWADDR_M1 = 32'h0002_0004;
    cyc("rst_g");
    AWVALID_M0 = 0; AWVALID_M1 = 0;
    AWREADY_M0 = 1; cyc("rst_aw"); AWREADY_M0 = 0;
    ARESET = 1;
    #1;
    model_reset();
    check_outputs("rst_async");
    cyc("rst_hold");
    ARESET = 0;
    AWVALID_M0 = 1; AWVALID_M1 = 1;
    cyc("rst_after");
    chk("rst_m0_wins", 32'(AW_arbiter), 32'd1);
    AWVALID_M0 = 0; AWVALID_M1 = 0;
    complete("rst_c");

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      ARESET     = ($urandom_range(0, 99) == 0);
      AWVALID_M0 = $urandom_range(0, 1);
      AWVALID_M1 = $urandom_range(0, 1);
      AWADDR_M0  = ($urandom_range(0, 3) == 0) ? $urandom() : addr_tab[$urandom_range(0, 11)];
      AWADDR_M1  = ($urandom_range(0, 3) == 0) ? $urandom() : addr_tab[$urandom_range(0, 11)];
      AWREADY_M0 = ($urandom_range(0, 2) == 0);
      AWREADY_M1 = ($urandom_range(0, 2) == 0);
      BVALID_M0  = $urandom_range(0, 1);
      BREADY_M0  = $urandom_range(0, 1);
      BVALID_M1  = $urandom_range(0, 1);
      BREADY_M1  = $urandom_range(0, 1);
      cyc("rand");
    end
    ARESET = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
